// File: rtl/contador_asc_desc_hex.sv
// -----------------------------------------------------------------------------
// contador_asc_desc_hex
//
// Upstream stage of the binary-to-hex 7-segment decoder. A free-running
// prescaler divides clk into a slow tick, and a 4-bit up/down hex count
// advances once per tick while enabled. The count goes to the decoder on
// digito, and the decoder enable switch is forwarded one clock later so the
// display turns on aligned with the registered count.
//
// Parameters:
//   DIV_MAX  prescaler terminal value; one tick every DIV_MAX+1 clk cycles
//   PRESC_W  prescaler width, 2**PRESC_W must exceed DIV_MAX
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous reset, active-low
//   enable     in   count enable switch (also forwarded to the decoder)
//   up_down    in   1 = ascending, 0 = descending
//   clear      in   synchronous clear of the count, active-high
//   digito     out  [3:0] current count
//   enable_out out  enable delayed by one clk
//   tick       out  one-clk pulse when the prescaler wraps
//   tc         out  one-clk terminal-count pulse, coincident with the new count
//
// Build option:
//   SATURATE_EN  when defined, the count saturates at 4'hF (ascending) and
//                4'h0 (descending) instead of wrapping; tc pulses once on the
//                update that reaches the limit.
// -----------------------------------------------------------------------------
module contador_asc_desc_hex #(
   parameter int unsigned DIV_MAX = 49999999,
   parameter int          PRESC_W = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       up_down,
   input  logic       clear,
   output logic [3:0] digito,
   output logic       enable_out,
   output logic       tick,
   output logic       tc
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV_MAX);
   localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

   logic [PRESC_W-1:0] presc;

   // The count update is qualified by the registered tick, so a new digito
   // appears on the edge that closes the tick cycle (1 clk after tick).
   logic count_step;
   assign count_step = tick & enable;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc      <= '0;
         tick       <= 1'b0;
         tc         <= 1'b0;
         digito     <= 4'h0;
         enable_out <= 1'b0;
      end else begin
         enable_out <= enable;

         // Prescaler runs regardless of enable and clear.
         if (presc == PRESC_LAST) begin
            presc <= '0;
            tick  <= 1'b1;
         end else begin
            presc <= presc + PRESC_ONE;
            tick  <= 1'b0;
         end

         // tc defaults low; only a terminal step raises it for one clk.
         tc <= 1'b0;

         if (clear) begin
            digito <= 4'h0;
         end else if (count_step) begin
            if (up_down) begin
`ifdef SATURATE_EN
               if (digito != 4'hF) begin
                  digito <= digito + 4'h1;
                  tc     <= (digito == 4'hE);
               end
`else
               digito <= digito + 4'h1;
               tc     <= (digito == 4'hF);
`endif
            end else begin
`ifdef SATURATE_EN
               if (digito != 4'h0) begin
                  digito <= digito - 4'h1;
                  tc     <= (digito == 4'h1);
               end
`else
               digito <= digito - 4'h1;
               tc     <= (digito == 4'h0);
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_contador_asc_desc_hex.sv
// -----------------------------------------------------------------------------
// tb_contador_asc_desc_hex
//
// Bench for contador_asc_desc_hex with DIV_MAX=3. A reference model counts
// clock edges since reset release to place ticks, and tracks the hex count
// with plain integer arithmetic. Inputs change on the falling edge; outputs
// are compared against the model on every falling edge.
// -----------------------------------------------------------------------------
module tb_contador_asc_desc_hex;

   localparam int DIV_MAX = 3;
   localparam int PERIOD  = DIV_MAX + 1;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       up_down;
   logic       clear;
   logic [3:0] digito;
   logic       enable_out;
   logic       tick;
   logic       tc;

   int checks   = 0;
   int failures = 0;

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   contador_asc_desc_hex #(
      .DIV_MAX (DIV_MAX),
      .PRESC_W (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .up_down    (up_down),
      .clear      (clear),
      .digito     (digito),
      .enable_out (enable_out),
      .tick       (tick),
      .tc         (tc)
   );

   // ---------------- reference model ----------------
   bit m_valid = 1'b0;
   int m_edges;          // clock edges since reset release
   int m_dig;
   bit m_tick;
   bit m_tc;
   bit m_en;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1'b1;
         m_edges = 0;
         m_dig   = 0;
         m_tick  = 1'b0;
         m_tc    = 1'b0;
         m_en    = 1'b0;
      end else if (m_valid) begin
         m_tc = 1'b0;
         if (clear) begin
            m_dig = 0;
         end else if (m_tick && enable) begin
            if (up_down) begin
`ifdef SATURATE_EN
               if (m_dig < 15) begin
                  m_dig = m_dig + 1;
                  m_tc  = (m_dig == 15);
               end
`else
               m_tc  = (m_dig == 15);
               m_dig = (m_dig + 1) % 16;
`endif
            end else begin
`ifdef SATURATE_EN
               if (m_dig > 0) begin
                  m_dig = m_dig - 1;
                  m_tc  = (m_dig == 0);
               end
`else
               m_tc  = (m_dig == 0);
               m_dig = (m_dig + 15) % 16;
`endif
            end
         end
         m_en    = enable;
         m_edges = m_edges + 1;
         m_tick  = (m_edges % PERIOD) == 0;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("digito", int'(digito), m_dig);
         chk("tick", int'(tick), int'(m_tick));
         chk("tc", int'(tc), int'(m_tc));
         chk("enable_out", int'(enable_out), int'(m_en));
      end
   end

   // ---------------- driver tasks ----------------
   // Waits for a tick cycle, then one more falling edge so the count update
   // that follows the tick is visible.
   task automatic step_tick();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n = n + 1;
      end while (!tick && n < 4 * PERIOD);
      if (!tick) begin
         checks   = checks + 1;
         failures = failures + 1;
         $display("FAIL tick_timeout: no tick within %0d cycles", n);
      end
      @(negedge clk);
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step_tick();
   endtask

   // Counts falling edges until tick is seen; bounded.
   task automatic gap_to_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n = n + 1;
      end while (!tick && n < 4 * PERIOD);
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int gap;
      rst_n   = 1'b0;
      enable  = 1'b1;
      up_down = 1'b1;
      clear   = 1'b0;

      // Reset for 2 clk; everything zero.
      repeat (2) @(negedge clk);
      chk("rst_digito", int'(digito), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_tc", int'(tc), 0);
      chk("rst_enable_out", int'(enable_out), 0);

      // Release ascending: first tick DIV_MAX+1 clk after release.
      rst_n = 1'b1;
      gap_to_tick(gap);
      chk("first_tick_gap", gap, PERIOD);
      @(negedge clk);
      chk("asc_first", int'(digito), 1);
      steps(2);
      chk("asc_three", int'(digito), 3);
      gap_to_tick(gap);
      chk("tick_period", gap, PERIOD - 1);
      @(negedge clk);
      chk("asc_four", int'(digito), 4);

      // Ascending to the top.
      steps(11);
      chk("asc_f", int'(digito), 15);
`ifdef SATURATE_EN
      chk("asc_f_tc", int'(tc), 1);
`else
      chk("asc_f_tc", int'(tc), 0);
`endif
      step_tick();
`ifdef SATURATE_EN
      chk("asc_top_digito", int'(digito), 15);
      chk("asc_top_tc", int'(tc), 0);
`else
      chk("asc_wrap_digito", int'(digito), 0);
      chk("asc_wrap_tc", int'(tc), 1);
`endif
      @(negedge clk);
      chk("tc_one_clk", int'(tc), 0);

      // Descending from reset.
      do_reset(2);
      up_down = 1'b0;
      rst_n   = 1'b1;
      step_tick();
`ifdef SATURATE_EN
      chk("desc_1", int'(digito), 0);
      chk("desc_1_tc", int'(tc), 0);
      steps(2);
      chk("desc_3", int'(digito), 0);
`else
      chk("desc_1", int'(digito), 15);
      chk("desc_1_tc", int'(tc), 1);
      step_tick();
      chk("desc_2", int'(digito), 14);
      step_tick();
      chk("desc_3", int'(digito), 13);
`endif

      // Hold at 5 with enable=0.
      do_reset(1);
      up_down = 1'b1;
      rst_n   = 1'b1;
      steps(5);
      chk("hold_start", int'(digito), 5);
      enable = 1'b0;
      @(negedge clk);
      chk("enable_out_delay", int'(enable_out), 0);
      steps(3);
      chk("hold_digito", int'(digito), 5);
      chk("hold_tc", int'(tc), 0);
      enable = 1'b1;

      // Clear coincident with a tick at 9.
      steps(4);
      chk("pre_clear", int'(digito), 9);
      gap_to_tick(gap);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clear_digito", int'(digito), 0);
      chk("clear_tc", int'(tc), 0);
      gap_to_tick(gap);
      chk("clear_phase", gap, PERIOD - 1);
      @(negedge clk);
      chk("after_clear", int'(digito), 1);

      // Reset mid-count at A with prescaler=2.
      steps(9);
      chk("pre_midrst", int'(digito), 10);
      @(negedge clk);
      do_reset(1);
      chk("midrst_digito", int'(digito), 0);
      rst_n = 1'b1;
      gap_to_tick(gap);
      chk("midrst_gap", gap, PERIOD);

      // Randomized phase, scoreboard checks every cycle.
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         rst_n   = ($urandom_range(0, 149) != 0);
         enable  = ($urandom_range(0, 3) != 0);
         clear   = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 15) == 0) up_down = ~up_down;
      end
      rst_n = 1'b1;
      clear = 1'b0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit.
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "time limit");
   end

endmodule
